pll_power_sequencer: RTL and testbench
======================================

# pll_power_sequencer

Sequences PLL power-down and power-up for low-power image readout, on the always-running on-chip oscillator clock (18 MHz). Between the PLL-control CSR, the PLL, and the dynamic clock select (DCS) that feeds the JPEG/image-buffer domain. Converts a software sleep request into an ordered sequence: drain camera, move DCS to SPI clock, power down PLL. Reverses it on wake, and gates the jpeg domain reset until the PLL is locked and settled.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for async inputs
- DCS_GUARD_CYCLES, 8, hold cycles after any DCS select change
- LOCK_SETTLE_CYCLES, 1024, lock must stay high this long before RUN
- LOCK_TIMEOUT_CYCLES, 65535, max wait for lock per attempt
- RETRY_OFF_CYCLES, 64, PLL off time before a relock retry

Ports:
- clock_in  input  1  oscillator clock
- reset_n_in  input  1  asynchronous, active-low reset
- sleep_request_in  input  1  level from CSR (SPI domain), synchronized internally
- camera_idle_in  input  1  camera/JPEG not capturing (pixel domain), synchronized internally
- pll_locked_in  input  1  raw PLL lock, synchronized internally
- pllpowerdown_n_out  output  1  to PLL; 0 = powered down
- image_buffer_read_en_out  output  1  DCS select; 1 = SPI clock
- jpeg_reset_n_out  output  1  gates jpeg/jpeg_buffer reset syncs; 0 = hold in reset
- state_out  output  3  current state encoding, CSR readback
- lock_fault_out  output  1  sticky lock timeout flag

## Operation
States, encoding in brackets:
- WAKE_LOCK [0]: powerdown_n=1, read_en=1, jpeg_reset_n=0. Waits for synced lock. Timeout → set lock_fault, go to RETRY.
- SETTLE [1]: counts to LOCK_SETTLE_CYCLES while lock stays high. Any lock drop returns to WAKE_LOCK with counter cleared. Done → TO_PLL.
- TO_PLL [2]: read_en=0, holds DCS_GUARD_CYCLES → RUN.
- RUN [3]: powerdown_n=1, read_en=0, jpeg_reset_n=1. Synced sleep_request → DRAIN.
- DRAIN [4]: waits for synced camera_idle → TO_SPI. Request drop → RUN (abort).
- TO_SPI [5]: jpeg_reset_n=0, read_en=1, holds DCS_GUARD_CYCLES → SLEEP.
- SLEEP [6]: powerdown_n=0, read_en=1. Request drop → WAKE_LOCK.
- RETRY [7]: powerdown_n=0 for RETRY_OFF_CYCLES → WAKE_LOCK.

Rules:
- Entry into SLEEP clears lock_fault_out. Nothing else clears it except reset.
- Sleep request raised during WAKE_LOCK, SETTLE or TO_PLL is not honoured until RUN.
- Lock loss in RUN → WAKE_LOCK, with jpeg_reset_n=0 and read_en=1 on the next cycle.
- All outputs are registered. One shared down-counter, reloaded on every state entry.
- Counter width is clog2 of the largest parameter, minimum 1 bit.

## Timing
- Reset values: state WAKE_LOCK, powerdown_n=1, read_en=1, jpeg_reset_n=0, lock_fault=0, counter loaded with LOCK_TIMEOUT_CYCLES.
- Input-to-state latency is SYNC_STAGES cycles plus 1 registered cycle.
- Outputs change in the first cycle of the new state.
- read_en never changes in the same cycle as powerdown_n.
- powerdown_n never falls while read_en=0.
- jpeg_reset_n rises only on entry to RUN, which is at least DCS_GUARD_CYCLES after read_en fell.
- Minimum time from reset to RUN with lock already high: SYNC_STAGES + 1 + LOCK_SETTLE_CYCLES + DCS_GUARD_CYCLES.
- Timeout is hit when the counter reaches 0 in WAKE_LOCK: exactly LOCK_TIMEOUT_CYCLES cycles after entry.
- Async reset mid-sequence returns to WAKE_LOCK immediately.
- If the PLL was off, it is re-enabled in the reset-release cycle.

## Structure
- Shared package pll_power_pkg holds:
  - state enum pll_power_state_t (3-bit, encodings above)
  - default parameter constants, reused by the CSR readback decode
- Single sub-module sync_bit (SYNC_STAGES-deep flip-flop synchronizer, parameterised reset value), instantiated three times.
- Counter and FSM stay in pll_power_sequencer.

## Test plan
Parameters for all scenarios: SETTLE=16, GUARD=4, TIMEOUT=100, RETRY_OFF=8.
- Reset with lock high:
  - → RUN after 2+1+16+4 cycles
  - read_en falls 4 cycles before jpeg_reset_n rises
- Sleep request with camera_idle=0 for 50 cycles, then idle=1:
  - state stays DRAIN for those 50 cycles
  - then TO_SPI for 4 cycles, then SLEEP with powerdown_n=0
- Sleep request dropped in DRAIN:
  - → RUN
  - powerdown_n never pulses
  - read_en stays 0
- Lock held low after wake:
  - lock_fault=1 exactly 100 cycles after WAKE_LOCK entry
  - RETRY holds powerdown_n=0 for 8 cycles, then WAKE_LOCK again
- Lock glitches low at settle count 10:
  - SETTLE restarts from 16 after relock
  - RUN is reached only after an unbroken 16-cycle lock
- Reset asserted in SLEEP:
  - powerdown_n=1, read_en=1, jpeg_reset_n=0 combinationally on reset assertion
  - normal wake follows reset release

Source files
------------

// File: rtl/pll_power_pkg.sv
// Shared definitions for the PLL power sequencer: state encoding, default
// timing constants and the per-state output decode (also used by the CSR
// readback logic to interpret state_out).
package pll_power_pkg;

  // State encoding is visible to software through state_out, so it is fixed.
  typedef enum logic [2:0] {
    ST_WAKE_LOCK = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_TO_PLL    = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_TO_SPI    = 3'd5,
    ST_SLEEP     = 3'd6,
    ST_RETRY     = 3'd7
  } pll_power_state_t;

  // Default timing constants (cycles of the 18 MHz oscillator clock).
  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_DCS_GUARD_CYCLES    = 8;
  localparam int DEF_LOCK_SETTLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65535;
  localparam int DEF_RETRY_OFF_CYCLES    = 64;

  // Control outputs driven towards the PLL, the DCS and the jpeg reset syncs.
  typedef struct packed {
    logic pllpowerdown_n;  // 0 = PLL powered down
    logic read_en;         // DCS select, 1 = SPI clock
    logic jpeg_reset_n;    // 0 = jpeg domain held in reset
  } pll_power_outs_t;

  // Output levels for each state. The jpeg domain only leaves reset while it
  // is clocked from a locked PLL (RUN/DRAIN), and the PLL is only off while
  // the DCS is parked on the SPI clock (SLEEP/RETRY).
  function automatic pll_power_outs_t state_outputs(input pll_power_state_t st);
    pll_power_outs_t outs;
    outs = '{pllpowerdown_n: 1'b1, read_en: 1'b1, jpeg_reset_n: 1'b0};
    case (st)
      ST_WAKE_LOCK: outs = '{pllpowerdown_n: 1'b1, read_en: 1'b1, jpeg_reset_n: 1'b0};
      ST_SETTLE:    outs = '{pllpowerdown_n: 1'b1, read_en: 1'b1, jpeg_reset_n: 1'b0};
      ST_TO_PLL:    outs = '{pllpowerdown_n: 1'b1, read_en: 1'b0, jpeg_reset_n: 1'b0};
      ST_RUN:       outs = '{pllpowerdown_n: 1'b1, read_en: 1'b0, jpeg_reset_n: 1'b1};
      ST_DRAIN:     outs = '{pllpowerdown_n: 1'b1, read_en: 1'b0, jpeg_reset_n: 1'b1};
      ST_TO_SPI:    outs = '{pllpowerdown_n: 1'b1, read_en: 1'b1, jpeg_reset_n: 1'b0};
      ST_SLEEP:     outs = '{pllpowerdown_n: 1'b0, read_en: 1'b1, jpeg_reset_n: 1'b0};
      ST_RETRY:     outs = '{pllpowerdown_n: 1'b0, read_en: 1'b1, jpeg_reset_n: 1'b0};
      default:      outs = '{pllpowerdown_n: 1'b1, read_en: 1'b1, jpeg_reset_n: 1'b0};
    endcase
    return outs;
  endfunction

endpackage

// File: rtl/pll_power_sequencer_sync_bit.sv
// Multi-stage flip-flop synchronizer for a single asynchronous level.
// The reset value lets each input come out of reset in its safe state.
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  // At least one stage, even if a caller asks for zero.
  localparam int N = (STAGES < 1) ? 1 : STAGES;

  logic [N-1:0] sync_q;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {N{RESET_VAL}};
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < N; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/pll_power_sequencer.sv
// PLL power sequencer: turns a software sleep request into an ordered
// drain -> DCS-to-SPI -> PLL-off sequence, and reverses it on wake, keeping
// the jpeg domain in reset until the PLL has been locked and settled.
module pll_power_sequencer
  import pll_power_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int DCS_GUARD_CYCLES    = DEF_DCS_GUARD_CYCLES,
  parameter int LOCK_SETTLE_CYCLES  = DEF_LOCK_SETTLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int RETRY_OFF_CYCLES    = DEF_RETRY_OFF_CYCLES
) (
  input  logic       clock_in,
  input  logic       reset_n_in,
  input  logic       sleep_request_in,
  input  logic       camera_idle_in,
  input  logic       pll_locked_in,
  output logic       pllpowerdown_n_out,
  output logic       image_buffer_read_en_out,
  output logic       jpeg_reset_n_out,
  output logic [2:0] state_out,
  output logic       lock_fault_out
);

  // Counter sized for the largest timing constant; the +1 keeps the largest
  // load value representable when it is an exact power of two.
  localparam int MAX_A   = (DCS_GUARD_CYCLES > LOCK_SETTLE_CYCLES) ?
                           DCS_GUARD_CYCLES : LOCK_SETTLE_CYCLES;
  localparam int MAX_B   = (LOCK_TIMEOUT_CYCLES > RETRY_OFF_CYCLES) ?
                           LOCK_TIMEOUT_CYCLES : RETRY_OFF_CYCLES;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

  // Synchronized inputs.
  logic sleep_s;
  logic idle_s;
  logic lock_s;

  // Camera idle comes out of reset as "busy" so no drain can complete early.
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sleep (
    .clk_i  (clock_in),
    .rst_ni (reset_n_in),
    .d_i    (sleep_request_in),
    .q_o    (sleep_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_idle (
    .clk_i  (clock_in),
    .rst_ni (reset_n_in),
    .d_i    (camera_idle_in),
    .q_o    (idle_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_lock (
    .clk_i  (clock_in),
    .rst_ni (reset_n_in),
    .d_i    (pll_locked_in),
    .q_o    (lock_s)
  );

  pll_power_state_t   state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  pll_power_outs_t    outs_q, outs_d;
  logic               cnt_last;

  // Load value for the shared down-counter on entry into a state. States
  // that wait purely on inputs do not use the counter.
  function automatic logic [CNT_W-1:0] reload_for(input pll_power_state_t st);
    logic [CNT_W-1:0] val;
    val = '0;
    case (st)
      ST_WAKE_LOCK: val = CNT_W'(LOCK_TIMEOUT_CYCLES);
      ST_SETTLE:    val = CNT_W'(LOCK_SETTLE_CYCLES);
      ST_TO_PLL:    val = CNT_W'(DCS_GUARD_CYCLES);
      ST_TO_SPI:    val = CNT_W'(DCS_GUARD_CYCLES);
      ST_RETRY:     val = CNT_W'(RETRY_OFF_CYCLES);
      default:      val = '0;
    endcase
    return val;
  endfunction

  // The decrement that brings the counter to zero ends the timed state, so
  // a state loaded with N lasts exactly N cycles.
  assign cnt_last = (cnt_q <= CNT_W'(1));

  // Next-state, counter and sticky fault logic.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    cnt_d   = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;

    case (state_q)
      ST_WAKE_LOCK: begin
        if (lock_s) begin
          state_d = ST_SETTLE;
        end else if (cnt_last) begin
          state_d = ST_RETRY;
          fault_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        // Any drop in lock restarts the whole lock/settle wait.
        if (!lock_s) begin
          state_d = ST_WAKE_LOCK;
        end else if (cnt_last) begin
          state_d = ST_TO_PLL;
        end
      end
      ST_TO_PLL: begin
        if (cnt_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAKE_LOCK;
        end else if (sleep_s) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The jpeg domain is still on the PLL here, so a lock loss must pull
        // it back into reset just as in RUN.
        if (!lock_s) begin
          state_d = ST_WAKE_LOCK;
        end else if (!sleep_s) begin
          state_d = ST_RUN;
        end else if (idle_s) begin
          state_d = ST_TO_SPI;
        end
      end
      ST_TO_SPI: begin
        if (cnt_last) begin
          state_d = ST_SLEEP;
          fault_d = 1'b0;
        end
      end
      ST_SLEEP: begin
        if (!sleep_s) begin
          state_d = ST_WAKE_LOCK;
        end
      end
      ST_RETRY: begin
        if (cnt_last) begin
          state_d = ST_WAKE_LOCK;
        end
      end
      default: begin
        state_d = ST_WAKE_LOCK;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = reload_for(state_d);
    end

    outs_d = state_outputs(state_d);
  end

  // State, counter, fault and output registers; reset parks the PLL on and
  // the jpeg domain in reset on the SPI clock.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= ST_WAKE_LOCK;
      cnt_q   <= CNT_W'(LOCK_TIMEOUT_CYCLES);
      fault_q <= 1'b0;
      outs_q  <= state_outputs(ST_WAKE_LOCK);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      outs_q  <= outs_d;
    end
  end

  assign pllpowerdown_n_out       = outs_q.pllpowerdown_n;
  assign image_buffer_read_en_out = outs_q.read_en;
  assign jpeg_reset_n_out         = outs_q.jpeg_reset_n;
  assign state_out                = state_q;
  assign lock_fault_out           = fault_q;

endmodule

// File: tb/tb_pll_power_sequencer.sv
// Scenario bench for pll_power_sequencer with short timing parameters.
module tb_pll_power_sequencer;

  localparam int SYNC = 2;
  localparam int SETTLE = 16;
  localparam int GUARD = 4;
  localparam int TMO = 100;
  localparam int ROFF = 8;

  localparam logic [2:0] S_WAKE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_TOPLL  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_TOSPI  = 3'd5;
  localparam logic [2:0] S_SLEEP  = 3'd6;
  localparam logic [2:0] S_RETRY  = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sleep_req = 1'b0;
  logic       cam_idle = 1'b0;
  logic       locked = 1'b1;
  logic       pd_n;
  logic       rd_en;
  logic       jrst_n;
  logic [2:0] st;
  logic       fault;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [2:0] st;
    logic       flt;
  } exp_t;

  exp_t exp_q[$];
  exp_t ent;

  pll_power_sequencer #(
    .SYNC_STAGES         (SYNC),
    .DCS_GUARD_CYCLES    (GUARD),
    .LOCK_SETTLE_CYCLES  (SETTLE),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .RETRY_OFF_CYCLES    (ROFF)
  ) dut (
    .clock_in                 (clk),
    .reset_n_in               (rst_n),
    .sleep_request_in         (sleep_req),
    .camera_idle_in           (cam_idle),
    .pll_locked_in            (locked),
    .pllpowerdown_n_out       (pd_n),
    .image_buffer_read_en_out (rd_en),
    .jpeg_reset_n_out         (jrst_n),
    .state_out                (st),
    .lock_fault_out           (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
  endtask

  // {powerdown_n, read_en, jpeg_reset_n} required in each state.
  function automatic logic [2:0] exp_outs(input logic [2:0] s);
    logic [2:0] o;
    o = 3'b110;
    case (s)
      S_WAKE, S_SETTLE, S_TOSPI: o = 3'b110;
      S_TOPLL:                   o = 3'b100;
      S_RUN, S_DRAIN:            o = 3'b101;
      S_SLEEP, S_RETRY:          o = 3'b010;
      default:                   o = 3'b110;
    endcase
    return o;
  endfunction

  task automatic push_exp(input int c, input string tag, input logic [2:0] s, input logic f);
    exp_t e;
    e.cyc = c; e.tag = tag; e.st = s; e.flt = f;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: safety invariants every cycle, scoreboard entries at their cycle.
  initial begin
    logic prev_valid, prev_pd, prev_re;
    logic [2:0] o;
    prev_valid = 1'b0; prev_pd = 1'b1; prev_re = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_valid) begin
          check_eq("pd_re_same_cycle", {31'd0, (pd_n != prev_pd) && (rd_en != prev_re)}, 32'd0);
          check_eq("pd_fall_re0", {31'd0, prev_pd && !pd_n && !rd_en}, 32'd0);
        end
        prev_valid = 1'b1; prev_pd = pd_n; prev_re = rd_en;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (exp_q[i].cyc == cyc) begin
            ent = exp_q[i];
            exp_q.delete(i);
            o = exp_outs(ent.st);
            $display("[%0d] %s: state=%0d pd_n=%0b read_en=%0b jpeg_rst_n=%0b fault=%0b",
                     cyc, ent.tag, st, pd_n, rd_en, jrst_n, fault);
            check_eq({ent.tag, "/state"}, {29'd0, st}, {29'd0, ent.st});
            check_eq({ent.tag, "/pd_n"}, {31'd0, pd_n}, {31'd0, o[2]});
            check_eq({ent.tag, "/read_en"}, {31'd0, rd_en}, {31'd0, o[1]});
            check_eq({ent.tag, "/jpeg_rst_n"}, {31'd0, jrst_n}, {31'd0, o[0]});
            check_eq({ent.tag, "/fault"}, {31'd0, fault}, {31'd0, ent.flt});
          end
        end
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    n_checks++;
    $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, c0, w, d, s, e, g, h, r;
    // Reset with lock already high.
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst/state", {29'd0, st}, {29'd0, S_WAKE});
    check_eq("rst/pd_n", {31'd0, pd_n}, 32'd1);
    check_eq("rst/read_en", {31'd0, rd_en}, 32'd1);
    check_eq("rst/jpeg_rst_n", {31'd0, jrst_n}, 32'd0);
    check_eq("rst/fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
    push_exp(b + 2, "boot_wake", S_WAKE, 1'b0);
    push_exp(b + SYNC + 1, "boot_settle", S_SETTLE, 1'b0);
    push_exp(b + SYNC + SETTLE, "boot_settle_end", S_SETTLE, 1'b0);
    push_exp(b + SYNC + 1 + SETTLE, "boot_to_pll", S_TOPLL, 1'b0);
    push_exp(b + SYNC + SETTLE + GUARD, "boot_to_pll_end", S_TOPLL, 1'b0);
    push_exp(b + SYNC + 1 + SETTLE + GUARD, "boot_run", S_RUN, 1'b0);
    wait_cyc(b + 30);

    // Sleep request while camera busy for 50 cycles.
    c0 = cyc;
    sleep_req = 1'b1; cam_idle = 1'b0;
    push_exp(c0 + 2, "drain_pre", S_RUN, 1'b0);
    push_exp(c0 + 3, "drain_first", S_DRAIN, 1'b0);
    push_exp(c0 + 52, "drain_last", S_DRAIN, 1'b0);
    wait_cyc(c0 + 50);
    cam_idle = 1'b1;
    push_exp(c0 + 53, "to_spi_first", S_TOSPI, 1'b0);
    push_exp(c0 + 56, "to_spi_last", S_TOSPI, 1'b0);
    push_exp(c0 + 57, "sleep_entry", S_SLEEP, 1'b0);
    wait_cyc(c0 + 60);

    // Wake with lock high.
    w = cyc;
    sleep_req = 1'b0; cam_idle = 1'b0;
    push_exp(w + 3, "wake_lock", S_WAKE, 1'b0);
    push_exp(w + 4, "wake_settle", S_SETTLE, 1'b0);
    push_exp(w + 23, "wake_to_pll", S_TOPLL, 1'b0);
    push_exp(w + 24, "wake_run", S_RUN, 1'b0);
    wait_cyc(w + 30);

    // Sleep request dropped while draining.
    d = cyc;
    sleep_req = 1'b1;
    for (int k = 1; k <= 20; k++)
      push_exp(d + k, "abort", (k >= 3 && k <= 12) ? S_DRAIN : S_RUN, 1'b0);
    wait_cyc(d + 10);
    sleep_req = 1'b0;
    wait_cyc(d + 25);

    // Sleep, lose lock, wake into timeout and retry.
    s = cyc;
    sleep_req = 1'b1; cam_idle = 1'b1;
    push_exp(s + 3, "s2_drain", S_DRAIN, 1'b0);
    push_exp(s + 4, "s2_to_spi", S_TOSPI, 1'b0);
    push_exp(s + 8, "s2_sleep", S_SLEEP, 1'b0);
    wait_cyc(s + 10);
    locked = 1'b0;
    wait_cyc(s + 20);
    sleep_req = 1'b0; cam_idle = 1'b0;
    e = s + 23;
    push_exp(e - 1, "tmo_still_sleep", S_SLEEP, 1'b0);
    push_exp(e, "tmo_wake_entry", S_WAKE, 1'b0);
    push_exp(e + TMO - 1, "tmo_before", S_WAKE, 1'b0);
    push_exp(e + TMO, "tmo_fault", S_RETRY, 1'b1);
    push_exp(e + TMO + ROFF - 1, "retry_last", S_RETRY, 1'b1);
    push_exp(e + TMO + ROFF, "retry_done", S_WAKE, 1'b1);
    wait_cyc(e + TMO + ROFF + 2);

    // Relock, then a one-cycle lock glitch 10 cycles into SETTLE.
    g = cyc;
    locked = 1'b1;
    push_exp(g + 3, "glitch_settle", S_SETTLE, 1'b1);
    h = g + 10;
    wait_cyc(h);
    locked = 1'b0;
    push_exp(h + 2, "glitch_pre", S_SETTLE, 1'b1);
    push_exp(h + 3, "glitch_drop", S_WAKE, 1'b1);
    push_exp(h + 4, "glitch_resettle", S_SETTLE, 1'b1);
    push_exp(h + 19, "glitch_settle_end", S_SETTLE, 1'b1);
    push_exp(h + 20, "glitch_to_pll", S_TOPLL, 1'b1);
    push_exp(h + 24, "glitch_run", S_RUN, 1'b1);
    wait_cyc(h + 1);
    locked = 1'b1;
    wait_cyc(h + 30);

    // Sleep clears the fault, then reset is asserted in SLEEP.
    r = cyc;
    sleep_req = 1'b1; cam_idle = 1'b1;
    push_exp(r + 8, "s3_sleep_clr", S_SLEEP, 1'b0);
    wait_cyc(r + 12);
    rst_n = 1'b0;
    #1;
    check_eq("arst/state", {29'd0, st}, {29'd0, S_WAKE});
    check_eq("arst/pd_n", {31'd0, pd_n}, 32'd1);
    check_eq("arst/read_en", {31'd0, rd_en}, 32'd1);
    check_eq("arst/jpeg_rst_n", {31'd0, jrst_n}, 32'd0);
    sleep_req = 1'b0; cam_idle = 1'b0;
    wait_cyc(r + 15);
    rst_n = 1'b1;
    b = cyc;
    push_exp(b + 2, "rewake_lock", S_WAKE, 1'b0);
    push_exp(b + 3, "rewake_settle", S_SETTLE, 1'b0);
    push_exp(b + 23, "rewake_run", S_RUN, 1'b0);
    wait_cyc(b + 30);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
